// File: rtl/mul_reservation_station.sv
// mul_reservation_station: multiplier-unit reservation station for the Tomasulo core.
// Holds issued MUL instructions, snoops the CDB for pending operand tags and
// dispatches one ready instruction at a time, waiting for its result on the CDB.
// Optional macro MUL_RS_OLDEST_FIRST_EN: dispatch the oldest ready entry
// (2-bit wrapping age stamps) instead of the lowest-index ready entry.
module mul_reservation_station #(
    parameter int NUM_ENTRIES = 2,
    parameter int TAG_BASE    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [2:0]             issue_qj,
    input  logic [7:0]             issue_vj,
    input  logic [2:0]             issue_qk,
    input  logic [7:0]             issue_vk,
    output logic [2:0]             issue_tag,
    input  logic                   cdb_valid,
    input  logic [2:0]             cdb_tag,
    input  logic [7:0]             cdb_data,
    output logic                   mul_start,
    output logic [2:0]             mul_tag,
    output logic [7:0]             mul_op_a,
    output logic [7:0]             mul_op_b,
    output logic [NUM_ENTRIES-1:0] busy_vec
);

    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic {S_IDLE, S_EXEC} state_e;

    state_e                 state_q, state_d;
    logic [NUM_ENTRIES-1:0] busy_q, busy_d, disp_q, disp_d, ready;
    logic [2:0]             qj_q [NUM_ENTRIES];
    logic [2:0]             qj_d [NUM_ENTRIES];
    logic [2:0]             qk_q [NUM_ENTRIES];
    logic [2:0]             qk_d [NUM_ENTRIES];
    logic [7:0]             vj_q [NUM_ENTRIES];
    logic [7:0]             vj_d [NUM_ENTRIES];
    logic [7:0]             vk_q [NUM_ENTRIES];
    logic [7:0]             vk_d [NUM_ENTRIES];
    logic                   mul_start_q, mul_start_d;
    logic [2:0]             mul_tag_q, mul_tag_d;
    logic [7:0]             op_a_q, op_a_d, op_b_q, op_b_d;
    logic [IW-1:0]          exec_idx_q, exec_idx_d;
    logic [IW-1:0]          alloc_idx, sel_idx;
    logic                   alloc_found, sel_found;
    logic                   issue_fire, dispatch_fire, complete_fire;
`ifdef MUL_RS_OLDEST_FIRST_EN
    logic [1:0]             age_cnt_q, age_cnt_d, best_dist;
    logic [1:0]             age_q    [NUM_ENTRIES];
    logic [1:0]             age_d    [NUM_ENTRIES];
    logic [1:0]             age_dist [NUM_ENTRIES];
`endif

    // Lowest-index free entry receives the next issue.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IW'(i);
            end
        end
    end

    assign issue_ready = alloc_found;
    assign issue_tag   = alloc_found ? 3'(TAG_BASE + int'(alloc_idx)) : 3'd0;
    assign issue_fire  = issue_valid && alloc_found;

    // An entry may dispatch once both operands are captured and it is not already in flight.
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready[i] = busy_q[i] && !disp_q[i] && (qj_q[i] == 3'd0) && (qk_q[i] == 3'd0);
        end
    end

    // Choose which ready entry the dispatcher takes.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef MUL_RS_OLDEST_FIRST_EN
        // Distance back from the issue counter: larger means issued earlier.
        best_dist = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            age_dist[i] = age_cnt_q - age_q[i] - 2'd1;
            if (ready[i] && (!sel_found || (age_dist[i] > best_dist))) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                best_dist = age_dist[i];
            end
        end
`else
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
`endif
    end

    // Dispatcher next state: present one operation, then wait for its tag on the CDB.
    always_comb begin
        state_d       = state_q;
        mul_start_d   = 1'b0;
        mul_tag_d     = mul_tag_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        exec_idx_d    = exec_idx_q;
        dispatch_fire = 1'b0;
        complete_fire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    dispatch_fire = 1'b1;
                    mul_start_d   = 1'b1;
                    mul_tag_d     = 3'(TAG_BASE + int'(sel_idx));
                    op_a_d        = vj_q[sel_idx];
                    op_b_d        = vk_q[sel_idx];
                    exec_idx_d    = sel_idx;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cdb_valid && (cdb_tag == mul_tag_q)) begin
                    complete_fire = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Entry updates: CDB snoop, dispatch marking, completion free, and issue capture with bypass.
    always_comb begin
        busy_d = busy_q;
        disp_d = disp_q;
        qj_d   = qj_q;
        vj_d   = vj_q;
        qk_d   = qk_q;
        vk_d   = vk_q;
`ifdef MUL_RS_OLDEST_FIRST_EN
        age_d     = age_q;
        age_cnt_d = issue_fire ? age_cnt_q + 2'd1 : age_cnt_q;
`endif
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (busy_q[i] && cdb_valid && (cdb_tag != 3'd0)) begin
                if (qj_q[i] == cdb_tag) begin
                    qj_d[i] = 3'd0;
                    vj_d[i] = cdb_data;
                end
                if (qk_q[i] == cdb_tag) begin
                    qk_d[i] = 3'd0;
                    vk_d[i] = cdb_data;
                end
            end
            if (dispatch_fire && (sel_idx == IW'(i))) begin
                disp_d[i] = 1'b1;
            end
            if (complete_fire && (exec_idx_q == IW'(i))) begin
                busy_d[i] = 1'b0;
                disp_d[i] = 1'b0;
            end
            if (issue_fire && (alloc_idx == IW'(i))) begin
                busy_d[i] = 1'b1;
                disp_d[i] = 1'b0;
                if (cdb_valid && (issue_qj != 3'd0) && (cdb_tag == issue_qj)) begin
                    qj_d[i] = 3'd0;
                    vj_d[i] = cdb_data;
                end else begin
                    qj_d[i] = issue_qj;
                    vj_d[i] = issue_vj;
                end
                if (cdb_valid && (issue_qk != 3'd0) && (cdb_tag == issue_qk)) begin
                    qk_d[i] = 3'd0;
                    vk_d[i] = cdb_data;
                end else begin
                    qk_d[i] = issue_qk;
                    vk_d[i] = issue_vk;
                end
`ifdef MUL_RS_OLDEST_FIRST_EN
                age_d[i] = age_cnt_q;
`endif
            end
        end
    end

    // State registers; reset discards every entry and any in-flight dispatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
            state_q     <= S_IDLE;
            busy_q      <= '0;
            disp_q      <= '0;
            mul_start_q <= 1'b0;
            mul_tag_q   <= 3'd0;
            op_a_q      <= 8'd0;
            op_b_q      <= 8'd0;
            exec_idx_q  <= '0;
            // NOTE: the entry payload is a small flop array rather than a RAM, so it is reset like any other register.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                qj_q[i] <= 3'd0;
                vj_q[i] <= 8'd0;
                qk_q[i] <= 3'd0;
                vk_q[i] <= 8'd0;
`ifdef MUL_RS_OLDEST_FIRST_EN
                age_q[i] <= 2'd0;
`endif
            end
`ifdef MUL_RS_OLDEST_FIRST_EN
            age_cnt_q <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            disp_q      <= disp_d;
            mul_start_q <= mul_start_d;
            mul_tag_q   <= mul_tag_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            exec_idx_q  <= exec_idx_d;
            qj_q        <= qj_d;
            vj_q        <= vj_d;
            qk_q        <= qk_d;
            vk_q        <= vk_d;
`ifdef MUL_RS_OLDEST_FIRST_EN
            age_q       <= age_d;
            age_cnt_q   <= age_cnt_d;
`endif
        end
    end

    assign mul_start = mul_start_q;
    assign mul_tag   = mul_tag_q;
    assign mul_op_a  = op_a_q;
    assign mul_op_b  = op_b_q;
    assign busy_vec  = busy_q;

endmodule
